// File: rtl/ge_precomp_select.sv
// ge_precomp_select: constant-time streaming selector for one ge_precomp table entry.
// The entry is chosen by |b| and conditionally negated. The optional match_seen port is enabled by GE_SELECT_MATCH_FLAG_EN.
module ge_precomp_select #(
    parameter int NLIMB  = 10,
    parameter int LIMB_W = 32,
    parameter int DEPTH  = 8,
    parameter int B_W    = 5,
    parameter int FE_W   = NLIMB * LIMB_W
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [B_W-1:0]  b_in,
    output logic            busy,
    input  logic            entry_valid,
    output logic            entry_ready,
    input  logic [FE_W-1:0] entry_yplusx,
    input  logic [FE_W-1:0] entry_yminusx,
    input  logic [FE_W-1:0] entry_xy2d,
    output logic [FE_W-1:0] out_yplusx,
    output logic [FE_W-1:0] out_yminusx,
    output logic [FE_W-1:0] out_xy2d,
    output logic            out_valid,
    output logic            done
`ifdef GE_SELECT_MATCH_FLAG_EN
    ,
    output logic            match_seen
`endif
);

    localparam logic [1:0]      S_IDLE   = 2'd0;
    localparam logic [1:0]      S_LOAD   = 2'd1;
    localparam logic [1:0]      S_NEG    = 2'd2;
    localparam logic [B_W-1:0]  LAST_IDX = B_W'(DEPTH - 1);
    localparam logic [FE_W-1:0] FE_ONE   = {{(FE_W-1){1'b0}}, 1'b1};

    logic [1:0]      state_q, state_d;
    logic            bneg_q, bneg_d;
    logic [B_W-1:0]  babs_q, babs_d;
    logic [B_W-1:0]  cnt_q, cnt_d;
    logic [FE_W-1:0] acc_yp_q, acc_yp_d, acc_ym_q, acc_ym_d, acc_xy_q, acc_xy_d;
    logic [FE_W-1:0] out_yp_q, out_yp_d, out_ym_q, out_ym_d, out_xy_q, out_xy_d;
    logic            out_valid_q, out_valid_d;
    logic            done_q, done_d;
    logic            busy_q, busy_d;
    logic            ready_q, ready_d;
    logic            accept_s;
    logic            hit_s;
    logic [FE_W-1:0] mask_s;

    // Negate each limb independently; no carry crosses limb boundaries.
    function automatic logic [FE_W-1:0] fe_neg_limbs(input logic [FE_W-1:0] a);
        logic [FE_W-1:0] r;
        r = '0;
        for (int i = 0; i < NLIMB; i++) begin
            r[i*LIMB_W +: LIMB_W] = (~a[i*LIMB_W +: LIMB_W]) + LIMB_W'(1'b1);
        end
        return r;
    endfunction

    assign accept_s = (state_q == S_LOAD) && ready_q && entry_valid;
    assign hit_s    = ((cnt_q + B_W'(1'b1)) == babs_q);
    assign mask_s   = {FE_W{hit_s}};

    // Next-state logic: the accumulator update is always a masked mux so timing is independent of b.
    always_comb begin
        state_d     = state_q;
        bneg_d      = bneg_q;
        babs_d      = babs_q;
        cnt_d       = cnt_q;
        acc_yp_d    = acc_yp_q;
        acc_ym_d    = acc_ym_q;
        acc_xy_d    = acc_xy_q;
        out_yp_d    = out_yp_q;
        out_ym_d    = out_ym_q;
        out_xy_d    = out_xy_q;
        out_valid_d = out_valid_q;
        done_d      = 1'b0;
        busy_d      = busy_q;
        ready_d     = ready_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    bneg_d      = b_in[B_W-1];
                    babs_d      = b_in[B_W-1] ? (~b_in + B_W'(1'b1)) : b_in;
                    acc_yp_d    = FE_ONE;
                    acc_ym_d    = FE_ONE;
                    acc_xy_d    = '0;
                    cnt_d       = '0;
                    out_valid_d = 1'b0;
                    busy_d      = 1'b1;
                    ready_d     = 1'b1;
                    state_d     = S_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    acc_yp_d = (entry_yplusx & mask_s) | (acc_yp_q & ~mask_s);
                    acc_ym_d = (entry_yminusx & mask_s) | (acc_ym_q & ~mask_s);
                    acc_xy_d = (entry_xy2d & mask_s) | (acc_xy_q & ~mask_s);
                    cnt_d    = cnt_q + B_W'(1'b1);
                    if (cnt_q == LAST_IDX) begin
                        ready_d = 1'b0;
                        state_d = S_NEG;
                    end else begin
                        state_d = S_LOAD;
                    end
                end else begin
                    state_d = S_LOAD;
                end
            end
            S_NEG: begin
                if (bneg_q) begin
                    out_yp_d = acc_ym_q;
                    out_ym_d = acc_yp_q;
                    out_xy_d = fe_neg_limbs(acc_xy_q);
                end else begin
                    out_yp_d = acc_yp_q;
                    out_ym_d = acc_ym_q;
                    out_xy_d = acc_xy_q;
                end
                out_valid_d = 1'b1;
                done_d      = 1'b1;
                busy_d      = 1'b0;
                ready_d     = 1'b0;
                state_d     = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                ready_d = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            bneg_q      <= 1'b0;
            babs_q      <= '0;
            cnt_q       <= '0;
            acc_yp_q    <= '0;
            acc_ym_q    <= '0;
            acc_xy_q    <= '0;
            out_yp_q    <= '0;
            out_ym_q    <= '0;
            out_xy_q    <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            bneg_q      <= bneg_d;
            babs_q      <= babs_d;
            cnt_q       <= cnt_d;
            acc_yp_q    <= acc_yp_d;
            acc_ym_q    <= acc_ym_d;
            acc_xy_q    <= acc_xy_d;
            out_yp_q    <= out_yp_d;
            out_ym_q    <= out_ym_d;
            out_xy_q    <= out_xy_d;
            out_valid_q <= out_valid_d;
            done_q      <= done_d;
            busy_q      <= busy_d;
            ready_q     <= ready_d;
        end
    end

    assign busy        = busy_q;
    assign entry_ready = ready_q;
    assign out_yplusx  = out_yp_q;
    assign out_yminusx = out_ym_q;
    assign out_xy2d    = out_xy_q;
    assign out_valid   = out_valid_q;
    assign done        = done_q;

`ifdef GE_SELECT_MATCH_FLAG_EN
    logic match_q, match_d;

    // Match flag: cleared on accepted start, set once any position equals |b|.
    always_comb begin
        match_d = match_q;
        if ((state_q == S_IDLE) && start) begin
            match_d = 1'b0;
        end else if (accept_s && hit_s) begin
            match_d = 1'b1;
        end else begin
            match_d = match_q;
        end
    end

    // Match flag register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            match_q <= 1'b0;
        end else begin
            match_q <= match_d;
        end
    end

    assign match_seen = match_q;
`endif

endmodule

// File: tb/tb_ge_precomp_select.sv
// Directed testbench for ge_precomp_select; also covers match_seen when GE_SELECT_MATCH_FLAG_EN is defined.
module tb_ge_precomp_select;
    localparam int NLIMB  = 10;
    localparam int LIMB_W = 32;
    localparam int DEPTH  = 8;
    localparam int B_W    = 5;
    localparam int FE_W   = NLIMB * LIMB_W;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [B_W-1:0]  b_in = '0;
    logic            busy;
    logic            entry_valid = 1'b0;
    logic            entry_ready;
    logic [FE_W-1:0] entry_yplusx = '0;
    logic [FE_W-1:0] entry_yminusx = '0;
    logic [FE_W-1:0] entry_xy2d = '0;
    logic [FE_W-1:0] out_yplusx, out_yminusx, out_xy2d;
    logic            out_valid;
    logic            done;
`ifdef GE_SELECT_MATCH_FLAG_EN
    logic            match_seen;
`endif

    int   ntests = 0;
    int   nfail  = 0;
    logic wrap_mode = 1'b0;
    int   dcyc;

    ge_precomp_select #(.NLIMB(NLIMB), .LIMB_W(LIMB_W), .DEPTH(DEPTH), .B_W(B_W)) dut (
        .clk(clk), .rst(rst), .start(start), .b_in(b_in), .busy(busy),
        .entry_valid(entry_valid), .entry_ready(entry_ready),
        .entry_yplusx(entry_yplusx), .entry_yminusx(entry_yminusx), .entry_xy2d(entry_xy2d),
        .out_yplusx(out_yplusx), .out_yminusx(out_yminusx), .out_xy2d(out_xy2d),
        .out_valid(out_valid), .done(done)
`ifdef GE_SELECT_MATCH_FLAG_EN
        , .match_seen(match_seen)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [FE_W-1:0] fe_l0(input logic [LIMB_W-1:0] v);
        logic [FE_W-1:0] r;
        r = '0;
        r[LIMB_W-1:0] = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [FE_W-1:0] obs, input logic [FE_W-1:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_entry(input int k);
        if (k >= 1 && k <= DEPTH) begin
            entry_yplusx  = fe_l0(LIMB_W'(k));
            entry_yminusx = fe_l0(LIMB_W'(16 + k));
            entry_xy2d    = fe_l0(LIMB_W'(32 + k));
            if (wrap_mode && k == 1) entry_xy2d[9*LIMB_W +: LIMB_W] = 32'h8000_0000;
        end else begin
            entry_yplusx  = '0;
            entry_yminusx = '0;
            entry_xy2d    = '0;
        end
    endtask

    task automatic check_result(input string tag, input logic [FE_W-1:0] yp, input logic [FE_W-1:0] ym,
                                input logic [FE_W-1:0] xy, input logic m);
        check({tag, "_yplusx"}, out_yplusx, yp);
        check({tag, "_yminusx"}, out_yminusx, ym);
        check({tag, "_xy2d"}, out_xy2d, xy);
        check({tag, "_out_valid"}, FE_W'(out_valid), FE_W'(1'b1));
`ifdef GE_SELECT_MATCH_FLAG_EN
        check({tag, "_match_seen"}, FE_W'(match_seen), FE_W'(m));
`else
        if (m === 1'bx) $display("unexpected match argument");
`endif
    endtask

    // One selection: start, stream entries (optional stall / spurious starts / mid-run reset).
    task automatic run_sel(input logic [B_W-1:0] b, input int stall_after, input int stall_len,
                           input int rst_after, input logic spur, output int done_cyc);
        int   k;
        int   stalled;
        int   dcount;
        logic acc_pending;
        k = 1; stalled = 0; done_cyc = -1; acc_pending = 1'b0;
        @(negedge clk);
        start = 1'b1; b_in = b; entry_valid = 1'b1; drive_entry(1);
        @(posedge clk);
        for (int cyc = 1; cyc <= 40 && done_cyc < 0; cyc++) begin
            @(negedge clk);
            if (acc_pending) k++;
            if (done) done_cyc = cyc;
            start = spur && (done_cyc < 0);
            b_in  = spur ? 5'd1 : b;
            if (rst_after > 0 && k == rst_after + 1) begin
                rst = 1'b1;
                #1;
                check("rst_busy", FE_W'(busy), '0);
                check("rst_entry_ready", FE_W'(entry_ready), '0);
                check("rst_out_valid", FE_W'(out_valid), '0);
                check("rst_out_yplusx", out_yplusx, '0);
                check("rst_out_xy2d", out_xy2d, '0);
                start = 1'b0; entry_valid = 1'b0;
                @(negedge clk);
                rst = 1'b0;
                dcount = 0;
                for (int i = 0; i < 12; i++) begin
                    @(negedge clk);
                    if (done) dcount++;
                end
                check("rst_no_done", FE_W'(dcount), '0);
                return;
            end
            if (k == stall_after + 1 && stalled < stall_len) begin
                entry_valid = 1'b0;
                stalled++;
            end else begin
                entry_valid = (k <= DEPTH);
            end
            drive_entry(k);
            acc_pending = entry_valid && entry_ready;
        end
        start = 1'b0; entry_valid = 1'b0;
        if (done_cyc > 0) begin
            @(negedge clk);
            check("done_one_cycle", FE_W'(done), '0);
        end
    endtask

    initial begin
        #12;
        check("reset_busy", FE_W'(busy), '0);
        check("reset_entry_ready", FE_W'(entry_ready), '0);
        check("reset_out_valid", FE_W'(out_valid), '0);
        check("reset_done", FE_W'(done), '0);
        check("reset_out_yplusx", out_yplusx, '0);
        check("reset_out_yminusx", out_yminusx, '0);
        check("reset_out_xy2d", out_xy2d, '0);
        @(negedge clk);
        rst = 1'b0;

        run_sel(5'd3, 0, 0, 0, 1'b0, dcyc);
        check("b3_done_cycle", FE_W'(dcyc), FE_W'(10));
        check_result("b3", fe_l0(32'd3), fe_l0(32'd19), fe_l0(32'd35), 1'b1);

        run_sel(5'h1B, 0, 0, 0, 1'b0, dcyc);
        check("bm5_done_cycle", FE_W'(dcyc), FE_W'(10));
        check_result("bm5", fe_l0(32'd21), fe_l0(32'd5), fe_l0(32'hFFFF_FFDB), 1'b1);

        run_sel(5'd0, 0, 0, 0, 1'b0, dcyc);
        check_result("b0", fe_l0(32'd1), fe_l0(32'd1), '0, 1'b0);

        run_sel(5'h10, 0, 0, 0, 1'b0, dcyc);
        check("bm16_done_cycle", FE_W'(dcyc), FE_W'(10));
        check_result("bm16", fe_l0(32'd1), fe_l0(32'd1), '0, 1'b0);

        run_sel(5'd8, 4, 3, 0, 1'b1, dcyc);
        check("b8_stall_done_cycle", FE_W'(dcyc), FE_W'(13));
        check_result("b8_stall", fe_l0(32'd8), fe_l0(32'd24), fe_l0(32'd40), 1'b1);

        run_sel(5'd2, 0, 0, 3, 1'b0, dcyc);

        run_sel(5'd1, 0, 0, 0, 1'b0, dcyc);
        check("b1_done_cycle", FE_W'(dcyc), FE_W'(10));
        check_result("b1_after_rst", fe_l0(32'd1), fe_l0(32'd17), fe_l0(32'd33), 1'b1);

        wrap_mode = 1'b1;
        run_sel(5'h1F, 0, 0, 0, 1'b0, dcyc);
        check_result("bm1_wrap", fe_l0(32'd17), fe_l0(32'd1),
                     {32'h8000_0000, {8{32'h0000_0000}}, 32'hFFFF_FFDF}, 1'b1);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/ge_precomp_select.md
Name: ge_precomp_select

Overview:
- Sequential, constant-time table selector for ge_precomp points. Generalised successor of the single-shot three-field conditional move.
- Streams DEPTH table entries (yplusx, yminusx, xy2d), one per handshake. Keeps the entry whose 1-based position equals |b|, then conditionally negates the result when b<0.
- Sits between the precomputed-base-table ROM reader and the ge_madd stage of scalar-mult.
- Always consumes all DEPTH entries, whatever the value of b.

Parameters:
- NLIMB, 10, limbs per field element.
- LIMB_W, 32, bits per signed limb; FE_W = NLIMB*LIMB_W.
- DEPTH, 8, entries per table row (legal range 1..2^(B_W-1)-1).
- B_W, 5, width of signed select index b.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin selection; sampled only in IDLE.
- b_in  input  B_W  signed select index; captured on accepted start.
- busy  output  1  high from accepted start until done.
- entry_valid  input  1  table entry present.
- entry_ready  output  1  block accepts an entry; high only in LOAD.
- entry_yplusx  input  FE_W  table entry field.
- entry_yminusx  input  FE_W  table entry field.
- entry_xy2d  input  FE_W  table entry field.
- out_yplusx  output  FE_W  selected result.
- out_yminusx  output  FE_W  selected result.
- out_xy2d  output  FE_W  selected result.
- out_valid  output  1  result stable; held until next accepted start.
- done  output  1  one-cycle pulse when result becomes valid.

Behaviour:
- Reset (async, rst=1):
  - State IDLE.
  - busy, entry_ready, out_valid and done are 0.
  - All out_* fields are 0, and the accumulator is 0.
- States: IDLE -> LOAD -> NEG -> IDLE.
- IDLE, start=1:
  - Capture bneg = b_in[B_W-1] and babs = |b_in|.
  - Load accumulator with identity: yplusx = yminusx = fe_one (limb0=1, other limbs 0); xy2d = 0.
  - Set cnt=0, clear out_valid, go to LOAD.
- LOAD:
  - entry_ready=1.
  - On entry_valid&&entry_ready:
    - If (cnt+1)==babs, all three accumulator fields take the entry; otherwise they hold.
    - cnt increments.
  - When the accepted entry has cnt==DEPTH-1, go to NEG.
  - While entry_valid=0, nothing changes (stall of any length).
- NEG (one cycle, entry_ready=0):
  - If bneg: out_yplusx = acc.yminusx, out_yminusx = acc.yplusx, out_xy2d = per-limb two's-complement negation of acc.xy2d.
    - No carry between limbs.
    - A limb of -2^(LIMB_W-1) wraps to itself.
  - Else the accumulator copies straight to the outputs.
  - Set out_valid=1 and done=1 for this cycle's registered result. Clear busy. Go to IDLE.
- Latency: start accepted at cycle 0 with entry_valid held high gives done at cycle DEPTH+2.
- Boundary rules:
  - b=0: no entry matches; result is identity.
  - |b|>DEPTH, including b=-2^(B_W-1) whose magnitude is 2^(B_W-1): no match; result is identity. Negated identity equals identity.
  - start while busy: ignored; b is not recaptured.
  - start in the same cycle as done: ignored (state is not IDLE).
  - Reset mid-operation: abort immediately; no done pulse.
- Constant time: accumulator update is an unconditional mux driven by a mask; cycle count is independent of b.

Optional Feature:
- Macro GE_SELECT_MATCH_FLAG_EN.
- Defined:
  - Adds output port match_seen (1 bit).
  - Set when any entry's position equals babs; cleared on accepted start and on reset.
  - Valid alongside out_valid.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- b=3, DEPTH=8, entries k=1..8 with yplusx limb0=k, yminusx limb0=16+k, xy2d limb0=32+k, entry_valid always 1:
  - done at cycle 10.
  - out_yplusx limb0=3, out_yminusx limb0=19, out_xy2d limb0=35.
- b=-5, same table:
  - out_yplusx limb0=21, out_yminusx limb0=5, out_xy2d limb0=-37 (0xFFFFFFDB).
  - Other limbs 0.
- b=0 and b=-16:
  - Result is identity: out_yplusx = out_yminusx = limb0 1; out_xy2d all 0.
  - match_seen=0 when GE_SELECT_MATCH_FLAG_EN is defined.
- b=8, entry_valid deasserted for 3 cycles after entry 4:
  - done at cycle 13.
  - Result is entry 8.
  - start pulses during busy are ignored.
- b=2, assert rst after entry 3:
  - All outputs 0 asynchronously; no done.
  - A new start with b=1 then yields entry 1.
- b=-1, entry 1 xy2d limb9 = 0x80000000:
  - out_xy2d limb9 = 0x80000000 (wrap).
  - yplusx and yminusx are swapped.
